// File: rtl/frotaegis_pkg.sv
// Definitions shared by the capture and replay stream paths.
// Holds the stream width, the sample/frame defaults and the player state encoding.
package frotaegis_pkg;

    localparam int AXIS_WIDTH    = 32;
    localparam int DATA_SIZE_DEF = 12;
    localparam int LENGTH_DEF    = 32768;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } player_state_e;

endpackage

// File: rtl/axis_sample_player_if.sv
// AXI-Stream beat bundle for the MM2S replay channel.
// The DMA side is the master; the sample player is the slave.
interface axis_sample_player_if;
    import frotaegis_pkg::*;

    logic [AXIS_WIDTH-1:0] tdata;
    logic [3:0]            tkeep;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with combinational read of the head entry and a synchronous flush.
// Pushes while full and pops while empty are ignored; flush wins over both.
module sample_fifo #(
    parameter int WIDTH = 12,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [ADDR:0]    count
);
    localparam int            DEPTH     = 1 << ADDR;
    localparam logic [ADDR:0] DEPTH_CNT = (ADDR + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it was written, so resetting it would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/axis_sample_player.sv
// Replays MM2S stream samples as a paced Valid/Data strobe after priming a half-full FIFO.
// Also checks tlast placement against the frame length and flags output underruns.
module axis_sample_player
    import frotaegis_pkg::*;
#(
    parameter int DATA_SIZE   = DATA_SIZE_DEF,
    parameter int LENGTH      = LENGTH_DEF,
    parameter int LENGTH_SIZE = 15,
    parameter int FIFO_ADDR   = 4,
    parameter int PERIOD_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Enable,
    input  logic [PERIOD_SIZE-1:0] Period,
    axis_sample_player_if.slave    M_AXIS_MM2S_0,
    output logic                   Valid,
    output logic [DATA_SIZE-1:0]   Data,
    output logic                   FrameDone,
    output logic                   LastErr,
    output logic                   Underrun,
    output logic [LENGTH_SIZE-1:0] InCnt
);
    localparam logic [LENGTH_SIZE-1:0] LAST_BEAT   = LENGTH_SIZE'(LENGTH - 1);
    localparam logic [FIFO_ADDR:0]     PRIME_LEVEL = (FIFO_ADDR + 1)'(1 << (FIFO_ADDR - 1));

    player_state_e          state_q, state_d;
    logic [PERIOD_SIZE-1:0] pace_q, pace_d;
    logic [LENGTH_SIZE-1:0] in_cnt_q, in_cnt_d;
    logic [DATA_SIZE-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   last_err_q, last_err_d;
    logic                   underrun_q, underrun_d;

    logic                   tready, accept, at_last;
    logic                   fifo_flush, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_SIZE-1:0]   fifo_rdata;
    logic [FIFO_ADDR:0]     fifo_count;
    logic                   unused_axis;

    // Only registered state (plus the Enable level) feeds tready, so a same-cycle pop never frees a slot for a push.
    assign tready               = Enable & (state_q != ST_IDLE) & ~fifo_full;
    assign accept               = M_AXIS_MM2S_0.tvalid & tready;
    assign at_last              = (in_cnt_q == LAST_BEAT);
    assign M_AXIS_MM2S_0.tready = tready;
    assign unused_axis          = ^{M_AXIS_MM2S_0.tkeep, M_AXIS_MM2S_0.tdata[AXIS_WIDTH-1:DATA_SIZE]};

    sample_fifo #(
        .WIDTH (DATA_SIZE),
        .ADDR  (FIFO_ADDR)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (accept),
        .wdata (M_AXIS_MM2S_0.tdata[DATA_SIZE-1:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: every signal assigned below gets a default first, so no path through the block can infer a latch.
    always_comb begin
        state_d      = state_q;
        pace_d       = pace_q;
        in_cnt_d     = in_cnt_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        last_err_d   = last_err_q;
        underrun_d   = underrun_q;
        fifo_flush   = 1'b0;
        fifo_pop     = 1'b0;

        if (accept) begin
            frame_done_d = at_last;
            if (M_AXIS_MM2S_0.tlast != at_last) last_err_d = 1'b1;
            in_cnt_d = (M_AXIS_MM2S_0.tlast || at_last) ? '0 : in_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                fifo_flush = 1'b1;
                in_cnt_d   = '0;
                pace_d     = '0;
                if (Enable) begin
                    state_d    = ST_PRIME;
                    last_err_d = 1'b0;
                    underrun_d = 1'b0;
                end
            end
            ST_PRIME: begin
                if (fifo_count >= PRIME_LEVEL) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (pace_q == '0) begin
                    pace_d = (Period == '0) ? '0 : Period - 1'b1;
                    if (fifo_empty) begin
                        underrun_d = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                        valid_d  = 1'b1;
                        data_d   = fifo_rdata;
                    end
                end else begin
                    pace_d = pace_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping Enable abandons the current tick; a strobe registered last edge still leaves.
        if (!Enable) begin
            state_d    = ST_IDLE;
            fifo_flush = 1'b1;
            fifo_pop   = 1'b0;
            valid_d    = 1'b0;
            data_d     = data_q;
            underrun_d = underrun_q;
            in_cnt_d   = '0;
            pace_d     = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pace_q       <= '0;
            in_cnt_q     <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            last_err_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pace_q       <= pace_d;
            in_cnt_q     <= in_cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            last_err_q   <= last_err_d;
            underrun_q   <= underrun_d;
        end
    end

    assign Valid     = valid_q;
    assign Data      = data_q;
    assign FrameDone = frame_done_q;
    assign LastErr   = last_err_q;
    assign Underrun  = underrun_q;
    assign InCnt     = in_cnt_q;

endmodule

// File: tb/tb_axis_sample_player.sv
// Directed bench for axis_sample_player built with an 8-beat frame and a 16-entry FIFO.
// Cycle numbers count negedges after the one where Enable is raised.
module tb_axis_sample_player;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Enable = 1'b0;
    logic [7:0]  Period = 8'd1;
    logic        Valid;
    logic [11:0] Data;
    logic        FrameDone;
    logic        LastErr;
    logic        Underrun;
    logic [2:0]  InCnt;

    axis_sample_player_if axis_if ();

    axis_sample_player #(
        .DATA_SIZE   (12),
        .LENGTH      (8),
        .LENGTH_SIZE (3),
        .FIFO_ADDR   (4),
        .PERIOD_SIZE (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Enable        (Enable),
        .Period        (Period),
        .M_AXIS_MM2S_0 (axis_if),
        .Valid         (Valid),
        .Data          (Data),
        .FrameDone     (FrameDone),
        .LastErr       (LastErr),
        .Underrun      (Underrun),
        .InCnt         (InCnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int src_idx, src_end, early_last, frame_base;
    bit src_valid;
    int v_cyc[$];
    logic [11:0] v_data[$];
    int fd_cyc[$];
    int ur_first;

    task automatic drive_src();
        axis_if.tvalid = src_valid;
        axis_if.tkeep  = 4'hF;
        axis_if.tdata  = {20'hA5A5A, 12'(src_idx)};
        axis_if.tlast  = (src_idx == early_last) ||
                         (src_idx >= frame_base && ((src_idx - frame_base) % 8) == 7);
    endtask

    // Advance one clock: note whether the beat is taken, then log outputs at the next negedge.
    task automatic step();
        bit acc;
        #2;
        acc = axis_if.tvalid && axis_if.tready;
        @(negedge clk);
        cyc++;
        if (acc) begin
            src_idx++;
            if (src_idx >= src_end) src_valid = 1'b0;
            drive_src();
        end
        if (Valid === 1'b1) begin
            v_data.push_back(Data);
            v_cyc.push_back(cyc);
        end
        if (FrameDone === 1'b1) fd_cyc.push_back(cyc);
        if (Underrun === 1'b1 && ur_first < 0) ur_first = cyc;
    endtask

    task automatic restart(input int end_beat, input logic [7:0] per);
        rst = 1'b1;
        Enable = 1'b0;
        src_valid = 1'b0;
        src_idx = 0;
        src_end = end_beat;
        early_last = -1;
        frame_base = 0;
        drive_src();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        v_cyc.delete();
        v_data.delete();
        fd_cyc.delete();
        ur_first = -1;
        cyc = 0;
        Period = per;
        Enable = 1'b1;
        src_valid = 1'b1;
        drive_src();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (axis_if.tready !== 1'b0) begin n_bad++; $display("FAIL reset_tready: got %b want 0", axis_if.tready); end
        n_cmp++; if (Valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", Valid); end
        n_cmp++; if (Data !== 12'h000) begin n_bad++; $display("FAIL reset_data: got %h want 000", Data); end
        n_cmp++; if (FrameDone !== 1'b0) begin n_bad++; $display("FAIL reset_framedone: got %b want 0", FrameDone); end
        n_cmp++; if (LastErr !== 1'b0) begin n_bad++; $display("FAIL reset_lasterr: got %b want 0", LastErr); end
        n_cmp++; if (Underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b want 0", Underrun); end
        n_cmp++; if (InCnt !== 3'd0) begin n_bad++; $display("FAIL reset_incnt: got %0d want 0", InCnt); end
    endtask

    task automatic test_basic_replay();
        restart(16, 8'd4);
        #1;
        n_cmp++; if (axis_if.tready !== 1'b0) begin n_bad++; $display("FAIL basic_tready_c0: got %b want 0", axis_if.tready); end
        while (v_data.size() < 16 && cyc < 150) begin
            step();
            if (cyc == 1) begin
                n_cmp++; if (axis_if.tready !== 1'b1) begin n_bad++; $display("FAIL basic_tready_c1: got %b want 1", axis_if.tready); end
            end
        end
        n_cmp++; if (v_data.size() != 16) begin n_bad++; $display("FAIL basic_count: got %0d want 16", v_data.size()); end
        for (int k = 0; k < 16 && k < v_data.size(); k++) begin
            n_cmp++; if (v_data[k] !== 12'(k)) begin n_bad++; $display("FAIL basic_data[%0d]: got %0d want %0d", k, v_data[k], k); end
            n_cmp++; if (v_cyc[k] != 11 + 4 * k) begin n_bad++; $display("FAIL basic_cycle[%0d]: got %0d want %0d", k, v_cyc[k], 11 + 4 * k); end
        end
        n_cmp++; if (ur_first != -1) begin n_bad++; $display("FAIL basic_underrun: got first at %0d want none", ur_first); end
    endtask

    task automatic test_framing();
        restart(16, 8'd1);
        while (cyc < 20) begin
            step();
            if (cyc == 5) begin
                n_cmp++; if (InCnt !== 3'd4) begin n_bad++; $display("FAIL frame_incnt_c5: got %0d want 4", InCnt); end
            end
        end
        n_cmp++; if (fd_cyc.size() != 2) begin n_bad++; $display("FAIL frame_done_count: got %0d want 2", fd_cyc.size()); end
        if (fd_cyc.size() == 2) begin
            n_cmp++; if (fd_cyc[0] != 9) begin n_bad++; $display("FAIL frame_done0_cycle: got %0d want 9", fd_cyc[0]); end
            n_cmp++; if (fd_cyc[1] != 17) begin n_bad++; $display("FAIL frame_done1_cycle: got %0d want 17", fd_cyc[1]); end
        end
        n_cmp++; if (LastErr !== 1'b0) begin n_bad++; $display("FAIL frame_lasterr: got %b want 0", LastErr); end
        n_cmp++; if (InCnt !== 3'd0) begin n_bad++; $display("FAIL frame_incnt_end: got %0d want 0", InCnt); end
    endtask

    task automatic test_early_tlast();
        restart(16, 8'd1);
        early_last = 3;
        frame_base = 4;
        drive_src();
        while (cyc < 20) begin
            step();
            if (cyc == 4) begin
                n_cmp++; if (LastErr !== 1'b0) begin n_bad++; $display("FAIL early_lasterr_c4: got %b want 0", LastErr); end
            end
            if (cyc == 5) begin
                n_cmp++; if (LastErr !== 1'b1) begin n_bad++; $display("FAIL early_lasterr_c5: got %b want 1", LastErr); end
                n_cmp++; if (InCnt !== 3'd0) begin n_bad++; $display("FAIL early_incnt_c5: got %0d want 0", InCnt); end
                n_cmp++; if (FrameDone !== 1'b0) begin n_bad++; $display("FAIL early_framedone_c5: got %b want 0", FrameDone); end
            end
        end
        n_cmp++; if (fd_cyc.size() != 1) begin n_bad++; $display("FAIL early_done_count: got %0d want 1", fd_cyc.size()); end
        if (fd_cyc.size() == 1) begin
            n_cmp++; if (fd_cyc[0] != 13) begin n_bad++; $display("FAIL early_done_cycle: got %0d want 13", fd_cyc[0]); end
        end
        n_cmp++; if (LastErr !== 1'b1) begin n_bad++; $display("FAIL early_lasterr_sticky: got %b want 1", LastErr); end
    endtask

    task automatic test_backpressure();
        restart(60, 8'd10);
        while (v_data.size() < 25 && cyc < 400) begin
            step();
            if (cyc == 17) begin
                n_cmp++; if (axis_if.tready !== 1'b1) begin n_bad++; $display("FAIL bp_tready_c17: got %b want 1", axis_if.tready); end
            end
            if (cyc == 18) begin
                n_cmp++; if (axis_if.tready !== 1'b0) begin n_bad++; $display("FAIL bp_tready_c18: got %b want 0", axis_if.tready); end
            end
            if (cyc == 21) begin
                n_cmp++; if (axis_if.tready !== 1'b1) begin n_bad++; $display("FAIL bp_tready_c21: got %b want 1", axis_if.tready); end
            end
        end
        n_cmp++; if (v_data.size() != 25) begin n_bad++; $display("FAIL bp_count: got %0d want 25", v_data.size()); end
        for (int k = 0; k < 25 && k < v_data.size(); k++) begin
            n_cmp++; if (v_data[k] !== 12'(k)) begin n_bad++; $display("FAIL bp_data[%0d]: got %0d want %0d", k, v_data[k], k); end
            n_cmp++; if (v_cyc[k] != 11 + 10 * k) begin n_bad++; $display("FAIL bp_cycle[%0d]: got %0d want %0d", k, v_cyc[k], 11 + 10 * k); end
        end
    endtask

    task automatic test_underrun();
        restart(8, 8'd1);
        while (cyc < 25) step();
        n_cmp++; if (v_data.size() != 8) begin n_bad++; $display("FAIL ur_count: got %0d want 8", v_data.size()); end
        for (int k = 0; k < 8 && k < v_data.size(); k++) begin
            n_cmp++; if (v_data[k] !== 12'(k) || v_cyc[k] != 11 + k) begin
                n_bad++; $display("FAIL ur_strobe[%0d]: got %0d@%0d want %0d@%0d", k, v_data[k], v_cyc[k], k, 11 + k);
            end
        end
        n_cmp++; if (ur_first != 19) begin n_bad++; $display("FAIL ur_first: got %0d want 19", ur_first); end
        src_end = 12;
        src_valid = 1'b1;
        drive_src();
        while (cyc < 32) step();
        n_cmp++; if (v_data.size() != 12) begin n_bad++; $display("FAIL ur_resume_count: got %0d want 12", v_data.size()); end
        if (v_data.size() == 12) begin
            n_cmp++; if (v_data[8] !== 12'd8 || v_cyc[8] != 27) begin
                n_bad++; $display("FAIL ur_resume_first: got %0d@%0d want 8@27", v_data[8], v_cyc[8]);
            end
            n_cmp++; if (v_data[11] !== 12'd11) begin n_bad++; $display("FAIL ur_resume_last: got %0d want 11", v_data[11]); end
        end
        n_cmp++; if (Underrun !== 1'b1) begin n_bad++; $display("FAIL ur_sticky: got %b want 1", Underrun); end
    endtask

    task automatic test_disable_reset();
        restart(12, 8'd2);
        early_last = 3;
        frame_base = 4;
        drive_src();
        while (cyc < 23) step();
        n_cmp++; if (v_data.size() != 7) begin n_bad++; $display("FAIL dis_count: got %0d want 7", v_data.size()); end
        n_cmp++; if (LastErr !== 1'b1) begin n_bad++; $display("FAIL dis_lasterr_before: got %b want 1", LastErr); end
        Enable = 1'b0;
        #1;
        n_cmp++; if (Valid !== 1'b1 || Data !== 12'd6) begin n_bad++; $display("FAIL dis_pending: got %b/%0d want 1/6", Valid, Data); end
        n_cmp++; if (axis_if.tready !== 1'b0) begin n_bad++; $display("FAIL dis_tready: got %b want 0", axis_if.tready); end
        step();
        n_cmp++; if (Valid !== 1'b0) begin n_bad++; $display("FAIL dis_valid_c24: got %b want 0", Valid); end
        n_cmp++; if (InCnt !== 3'd0) begin n_bad++; $display("FAIL dis_incnt_c24: got %0d want 0", InCnt); end
        while (cyc < 27) step();
        n_cmp++; if (LastErr !== 1'b1) begin n_bad++; $display("FAIL dis_lasterr_idle: got %b want 1", LastErr); end
        v_data.delete();
        v_cyc.delete();
        Enable = 1'b1;
        Period = 8'd1;
        early_last = -1;
        frame_base = 12;
        src_end = 24;
        src_valid = 1'b1;
        drive_src();
        step();
        n_cmp++; if (LastErr !== 1'b0 || Underrun !== 1'b0) begin n_bad++; $display("FAIL dis_flags_cleared: got %b/%b want 0/0", LastErr, Underrun); end
        n_cmp++; if (axis_if.tready !== 1'b1) begin n_bad++; $display("FAIL dis_tready_prime: got %b want 1", axis_if.tready); end
        while (cyc < 40) step();
        n_cmp++; if (v_data.size() == 0 || v_data[0] !== 12'd12 || v_cyc[0] != 38) begin
            n_bad++; $display("FAIL dis_first_after: got %0d entries, first %0d@%0d want 12@38",
                              v_data.size(), (v_data.size() > 0) ? v_data[0] : 12'd0, (v_cyc.size() > 0) ? v_cyc[0] : -1);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({axis_if.tready, Valid, FrameDone, LastErr, Underrun} !== 5'b0) begin
            n_bad++; $display("FAIL async_rst_flags: got %b want 00000", {axis_if.tready, Valid, FrameDone, LastErr, Underrun});
        end
        n_cmp++; if (Data !== 12'd0 || InCnt !== 3'd0) begin n_bad++; $display("FAIL async_rst_data: got %0d/%0d want 0/0", Data, InCnt); end
        @(negedge clk);
        rst = 1'b0;
        Enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        src_valid = 1'b0;
        src_idx = 0;
        src_end = 0;
        early_last = -1;
        frame_base = 0;
        ur_first = -1;
        cyc = 0;
        drive_src();
        test_reset();
        test_basic_replay();
        test_framing();
        test_early_tlast();
        test_backpressure();
        test_underrun();
        test_disable_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_sample_player.md
# axis_sample_player

Receive-side counterpart of the S2MM capture stream. It accepts samples that the PS DMA reads out of DDR over the MM2S AXI-Stream channel and buffers them in a small FIFO. It replays them into the PL as a paced `Valid`/`Data` sample stream, so stored frames can stand in for `Data_Gen` as the input to `Frotaegis_Design`. It also checks frame framing (`tlast` position) and reports underruns.

## Interface
Parameters:
- `DATA_SIZE`, 12, sample width; taken from `tdata[DATA_SIZE-1:0]`.
- `LENGTH`, 32768, samples per frame; `tlast` is expected on beat `LENGTH-1`.
- `LENGTH_SIZE`, 15, width of the frame beat counter, log2(`LENGTH`).
- `FIFO_ADDR`, 4, FIFO depth is 2^`FIFO_ADDR` (16).
- `PERIOD_SIZE`, 8, width of `Period`.

Ports:
- `clk` in 1: single clock (FCLK-derived); all logic runs on it.
- `rst` in 1: reset, asynchronous assert, active-high.
- `Enable` in 1: run control; level-sensitive.
- `Period` in `PERIOD_SIZE`: output sample spacing in cycles; 0 and 1 both mean every cycle.
- `M_AXIS_MM2S_0_tdata` in 32: stream data; bits above `DATA_SIZE` are ignored.
- `M_AXIS_MM2S_0_tkeep` in 4: ignored.
- `M_AXIS_MM2S_0_tlast` in 1: end-of-frame marker.
- `M_AXIS_MM2S_0_tvalid` in 1: beat valid.
- `M_AXIS_MM2S_0_tready` out 1: `Enable & !full`, registered-state based.
- `Valid` out 1: one-cycle sample strobe.
- `Data` out `DATA_SIZE`: sample; holds its last value between strobes.
- `FrameDone` out 1: one-cycle pulse when beat `LENGTH-1` is accepted.
- `LastErr` out 1: sticky; `tlast` was misplaced or missing.
- `Underrun` out 1: sticky; a pacing tick found the FIFO empty.
- `InCnt` out `LENGTH_SIZE`: beat index of the next accepted beat.

## Operation
- A beat is accepted when `tvalid & tready`. The sample is pushed to the FIFO and `InCnt` increments.
- Framing check, applied on each accepted beat:
  - `tlast=1` at `InCnt==LENGTH-1`: correct. `InCnt` goes to 0.
  - `tlast=1` elsewhere: set `LastErr`. `InCnt` goes to 0, resynchronising to the stream.
  - `tlast=0` at `InCnt==LENGTH-1`: set `LastErr`. `InCnt` wraps to 0.
  - `FrameDone` pulses whenever `InCnt==LENGTH-1` on an accepted beat, regardless of `tlast`.
- Output FSM states: IDLE, PRIME, RUN.
  - IDLE: `tready=0`. The FIFO is held empty, `InCnt`=0, and the pacing counter is 0. `Enable=1` moves to PRIME and clears `LastErr` and `Underrun`.
  - PRIME: accept beats, no output. When the FIFO occupancy reaches 2^(`FIFO_ADDR`-1) (8), move to RUN.
  - RUN: the pace counter `PaceCnt` is 0 on entry. A tick occurs on every cycle with `PaceCnt==0`; the tick reloads `PaceCnt` with max(`Period`,1)-1, and any other cycle decrements it.
    - Tick with the FIFO non-empty: pop, register `Data`, and assert `Valid` the next cycle.
    - Tick with the FIFO empty: set `Underrun`, no `Valid`, remain in RUN.
  - Any state with `Enable=0`: go to IDLE on the next edge and flush the FIFO. A pending `Valid` already registered still appears.
- A push and a pop in the same cycle are allowed, and occupancy is unchanged. There is no push when the FIFO is full, even if a pop happens that cycle, because `tready` is derived from the registered full flag.

## Timing
- Reset values: `tready=0`, `Valid=0`, `Data=0`, `FrameDone=0`, `LastErr=0`, `Underrun=0`, `InCnt=0`, state IDLE.
- `rst` asserted mid-frame aborts immediately. The FIFO contents are discarded.
- `tready` rises one cycle after `Enable` rises (entry to PRIME).
- First `Valid`: one cycle after the RUN entry cycle.
- Steady state: one `Valid` every max(`Period`,1) cycles while data is available.
- `Period` is sampled at each tick reload, so a change takes effect after the current interval.
- `FrameDone` is asserted in the cycle after the acceptance edge. `LastErr` is set in the same cycle as `FrameDone`.

## Structure
- Shared package `frotaegis_pkg`:
  - `AXIS_WIDTH=32`.
  - The player state enum (IDLE/PRIME/RUN).
  - The `DATA_SIZE`/`LENGTH` defaults shared with the capture path.
- Sub-module `sample_fifo`: synchronous FIFO with parameters `WIDTH` and `ADDR`.
  - Outputs: `full`, `empty`, occupancy count.
  - Inputs: synchronous `flush`, async `rst`.
- The top level holds the framing counter, FSM, and pacing counter.

## Test plan
- **Basic replay:** `Enable=1`, `Period=4`, push samples 0..15 with `tvalid` held high. Expect the first `Valid` 1 cycle after RUN entry, which occurs after 8 beats are accepted. Then `Data`=0,1,2,… with `Valid` spaced exactly 4 cycles apart, and `Underrun=0` while the source keeps up.
- **Correct framing:** `LENGTH=8` build, two frames with `tlast` on beats 7 and 15. Expect `FrameDone` twice and `LastErr=0`.
- **Early `tlast` on beat 3:** expect `LastErr=1`, `InCnt=0` afterwards, and the next `FrameDone` 8 beats later.
- **Backpressure:** `Period=10`, continuous `tvalid`. Expect `tready=0` once 16 samples are buffered, no beat lost or duplicated, and the output order preserved.
- **Underrun:** `Period=1`, source stops after 8 beats. Expect 8 `Valid` strobes, then `Underrun=1` sticky. Resume the source: `Valid` restarts with the next sample.
- **Disable/reset mid-run:** drop `Enable` with 5 samples buffered, then re-enable. Expect the FIFO flushed, flags cleared, and PRIME re-entered. Async `rst` mid-frame: all outputs at reset values within the same cycle.
